// File: rtl/dp_types_pkg.sv
// Shared datapath/control types for the multicycle core.
package dp_types_pkg;

   localparam int SEQ_STATE_W = 3;

   typedef enum logic [SEQ_STATE_W-1:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5
   } seq_state_t;

endpackage

// File: rtl/llsc_link.sv
// LL/SC link register: remembers the last linked address and drops it on a
// successful SC or a matching coherence invalidation.
module llsc_link
   import dp_types_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              ll_done_i,
   input  logic              sc_clear_i,
   input  logic [ADDR_W-1:0] daddr_i,
   input  logic              snoop_inv_i,
   input  logic [ADDR_W-1:0] snoop_addr_i,
   output logic              sc_match_o
);

   logic              link_valid_q, link_valid_d;
   logic [ADDR_W-1:0] link_addr_q, link_addr_d;
   logic              snoop_hit_old, snoop_hit_new;

   assign snoop_hit_old = snoop_inv_i && (snoop_addr_i == link_addr_q);
   assign snoop_hit_new = snoop_inv_i && (snoop_addr_i == daddr_i);

   // A snoop on the line being linked in the same cycle means the LL never took.
   always_comb begin
      link_valid_d = link_valid_q;
      link_addr_d  = link_addr_q;
      if (ll_done_i) begin
         link_addr_d  = daddr_i;
         link_valid_d = !snoop_hit_new;
      end else if (sc_clear_i || snoop_hit_old) begin
         link_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         link_valid_q <= 1'b0;
         link_addr_q  <= '0;
      end else begin
         link_valid_q <= link_valid_d;
         link_addr_q  <= link_addr_d;
      end
   end

   assign sc_match_o = link_valid_q && (link_addr_q == daddr_i);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: steps each instruction FETCH..WB, gates the
// datapath write enables and cache requests, and keeps the performance counters.
//
// state  | meaning
// FETCH  | iREN held until ihit; irWEN pulses on ihit
// DECODE | control word settles, no enables
// EXEC   | ALU cycle; picks HALT / MEM / WB, latches SC pass
// MEM    | dREN or dWEN held until dhit; failed SC skips the request
// WB     | pcWEN, regWEN, sc_success; retires the instruction
// HALT   | sticky until RST, all enables low
module multicycle_sequencer
   import dp_types_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              ihit,
   input  logic              dhit,
   input  logic              dec_halt,
   input  logic              dec_regWEN,
   input  logic              dec_dREN,
   input  logic              dec_dWEN,
   input  logic              dec_datomic,
   input  logic [ADDR_W-1:0] daddr,
   input  logic              snoop_inv,
   input  logic [ADDR_W-1:0] snoop_addr,
   output logic              iREN,
   output logic              irWEN,
   output logic              dREN,
   output logic              dWEN,
   output logic              regWEN,
   output logic              pcWEN,
   output logic              sc_success,
   output logic              halt,
   output logic [CNT_W-1:0]  cycle_cnt,
   output logic [CNT_W-1:0]  instr_cnt
);

   seq_state_t       state_q, state_d;
   logic             sc_pass_q, sc_pass_d;
   logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
   logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
   logic             is_sc, is_ll, store_go;
   logic             sc_match, ll_done, sc_clear;

   assign is_sc    = dec_dWEN && dec_datomic;
   assign is_ll    = dec_dREN && dec_datomic;
   assign store_go = dec_dWEN && !(dec_datomic && !sc_pass_q);

   llsc_link #(.ADDR_W(ADDR_W)) u_link (
      .clk_i        (CLK),
      .rst_i        (RST),
      .ll_done_i    (ll_done),
      .sc_clear_i   (sc_clear),
      .daddr_i      (daddr),
      .snoop_inv_i  (snoop_inv),
      .snoop_addr_i (snoop_addr),
      .sc_match_o   (sc_match)
   );

   always_comb begin
      state_d    = state_q;
      sc_pass_d  = sc_pass_q;
      iREN       = 1'b0;
      irWEN      = 1'b0;
      dREN       = 1'b0;
      dWEN       = 1'b0;
      regWEN     = 1'b0;
      pcWEN      = 1'b0;
      sc_success = 1'b0;
      halt       = 1'b0;
      ll_done    = 1'b0;
      sc_clear   = 1'b0;
      case (state_q)
         FETCH: begin
            iREN = 1'b1;
            if (ihit) begin
               irWEN   = 1'b1;
               state_d = DECODE;
            end
         end
         DECODE: state_d = EXEC;
         EXEC: begin
            sc_pass_d = is_sc && sc_match;
            if (dec_halt)                  state_d = HALT;
            else if (dec_dREN || dec_dWEN) state_d = MEM;
            else                           state_d = WB;
         end
         MEM: begin
            // Loads win if the control word ever asserts both requests.
            if (dec_dREN) begin
               dREN = 1'b1;
               if (dhit) begin
                  ll_done = is_ll;
                  state_d = WB;
               end
            end else if (store_go) begin
               dWEN = 1'b1;
               if (dhit) state_d = WB;
            end else begin
               state_d = WB;
            end
         end
         WB: begin
            pcWEN      = 1'b1;
            regWEN     = dec_regWEN;
            sc_success = is_sc && sc_pass_q;
            sc_clear   = is_sc && sc_pass_q;
            state_d    = FETCH;
         end
         HALT:    halt = 1'b1;
         default: state_d = FETCH;
      endcase
   end

   always_comb begin
      cycle_cnt_d = cycle_cnt_q;
      instr_cnt_d = instr_cnt_q;
      if (state_q != HALT) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
      if (state_q == WB)   instr_cnt_d = instr_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= FETCH;
         sc_pass_q   <= 1'b0;
         cycle_cnt_q <= '0;
         instr_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         sc_pass_q   <= sc_pass_d;
         cycle_cnt_q <= cycle_cnt_d;
         instr_cnt_q <= instr_cnt_d;
      end
   end

   assign cycle_cnt = cycle_cnt_q;
   assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: directed vector table, hand-written corner
// sequences, then random instructions against an instruction-level model.
module tb_multicycle_sequencer;

   localparam int ADDR_W = 32;
   localparam int CNT_W  = 32;
   localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_LL = 3, K_SC = 4;

   logic              CLK = 1'b0;
   logic              RST = 1'b1;
   logic              ihit = 1'b0, dhit = 1'b0;
   logic              dec_halt = 1'b0, dec_regWEN = 1'b0;
   logic              dec_dREN = 1'b0, dec_dWEN = 1'b0, dec_datomic = 1'b0;
   logic [ADDR_W-1:0] daddr = '0;
   logic              snoop_inv = 1'b0;
   logic [ADDR_W-1:0] snoop_addr = '0;

   logic              iREN, irWEN, dREN, dWEN, regWEN, pcWEN, sc_success, halt;
   logic [CNT_W-1:0]  cycle_cnt, instr_cnt;

   logic              iREN4, irWEN4, dREN4, dWEN4, regWEN4, pcWEN4, sc4, halt4;
   logic [3:0]        cnt4, icnt4;

   int checks = 0;
   int errors = 0;
   int exp_cycles = 0;
   int exp_instr  = 0;

   bit          m_valid = 1'b0;
   logic [31:0] m_addr  = '0;

   typedef struct {
      int          kind;
      int          fi;
      int          dw;
      bit          rw;
      logic [31:0] addr;
      int          smode;
      logic [31:0] saddr;
      int          e_lat;
      int          e_dr;
      int          e_dw;
      bit          e_sc;
   } vec_t;

   vec_t tbl[$];

   always #5 CLK = ~CLK;

   multicycle_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
      .dec_halt(dec_halt), .dec_regWEN(dec_regWEN), .dec_dREN(dec_dREN),
      .dec_dWEN(dec_dWEN), .dec_datomic(dec_datomic), .daddr(daddr),
      .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
      .iREN(iREN), .irWEN(irWEN), .dREN(dREN), .dWEN(dWEN), .regWEN(regWEN),
      .pcWEN(pcWEN), .sc_success(sc_success), .halt(halt),
      .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
   );

   multicycle_sequencer #(.ADDR_W(ADDR_W), .CNT_W(4)) u_dut4 (
      .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
      .dec_halt(dec_halt), .dec_regWEN(dec_regWEN), .dec_dREN(dec_dREN),
      .dec_dWEN(dec_dWEN), .dec_datomic(dec_datomic), .daddr(daddr),
      .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
      .iREN(iREN4), .irWEN(irWEN4), .dREN(dREN4), .dWEN(dWEN4), .regWEN(regWEN4),
      .pcWEN(pcWEN4), .sc_success(sc4), .halt(halt4),
      .cycle_cnt(cnt4), .instr_cnt(icnt4)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input int kind, input int fi, input int dw, input bit rw,
                               input logic [31:0] addr, input int smode, input logic [31:0] saddr,
                               input int e_lat, input int e_dr, input int e_dw, input bit e_sc);
      vec_t v;
      v.kind = kind; v.fi = fi; v.dw = dw; v.rw = rw; v.addr = addr;
      v.smode = smode; v.saddr = saddr;
      v.e_lat = e_lat; v.e_dr = e_dr; v.e_dw = e_dw; v.e_sc = e_sc;
      return v;
   endfunction

   task automatic do_reset();
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      exp_cycles = 0;
      exp_instr  = 0;
      m_valid    = 1'b0;
      m_addr     = '0;
   endtask

   // Instruction-level reference: latency and request counts from the rules,
   // link tracked as an abstract (valid, address) pair.
   task automatic model(inout vec_t v);
      bit pass;
      if (v.smode == 1 && m_valid && v.saddr == m_addr) m_valid = 1'b0;
      v.e_dr = 0; v.e_dw = 0; v.e_sc = 1'b0;
      case (v.kind)
         K_ALU: v.e_lat = 4 + v.fi;
         K_LW: begin v.e_lat = 5 + v.fi + v.dw; v.e_dr = v.dw + 1; end
         K_SW: begin v.e_lat = 5 + v.fi + v.dw; v.e_dw = v.dw + 1; end
         K_LL: begin
            v.e_lat = 5 + v.fi + v.dw; v.e_dr = v.dw + 1;
            m_valid = !(v.smode == 2 && v.saddr == v.addr);
            m_addr  = v.addr;
         end
         default: begin
            pass = m_valid && (m_addr == v.addr);
            if (pass) begin
               v.e_lat = 5 + v.fi + v.dw; v.e_dw = v.dw + 1; v.e_sc = 1'b1;
               m_valid = 1'b0;
            end else begin
               v.e_lat = 5 + v.fi;
            end
         end
      endcase
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int fwait = 0, dreq = 0, lat = 0;
      int n_dr = 0, n_dw = 0, n_ir = 0, n_rw = 0, n_sc = 0;
      bit done = 1'b0, rw_at_pc = 1'b0, sc_at_pc = 1'b0;
      dec_halt    = 1'b0;
      dec_regWEN  = v.rw;
      dec_dREN    = (v.kind == K_LW || v.kind == K_LL);
      dec_dWEN    = (v.kind == K_SW || v.kind == K_SC);
      dec_datomic = (v.kind == K_LL || v.kind == K_SC);
      daddr       = v.addr;
      for (int c = 0; c < 200 && !done; c++) begin
         ihit = iREN && (fwait == v.fi);
         if (iREN) fwait++;
         dhit = (dREN || dWEN) && (dreq == v.dw);
         if (dREN || dWEN) dreq++;
         snoop_inv  = (v.smode == 1 && c == 0) || (v.smode == 2 && dhit);
         snoop_addr = v.saddr;
         #1;
         n_dr += int'(dREN);
         n_dw += int'(dWEN);
         n_ir += int'(irWEN);
         n_rw += int'(regWEN);
         n_sc += int'(sc_success);
         if (pcWEN) begin
            done     = 1'b1;
            rw_at_pc = regWEN;
            sc_at_pc = sc_success;
         end
         lat++;
         @(negedge CLK);
      end
      ihit = 1'b0; dhit = 1'b0; snoop_inv = 1'b0;
      exp_cycles += lat;
      exp_instr++;
      chk({tag, " retired"}, done, 1);
      chk({tag, " latency"}, lat, v.e_lat);
      chk({tag, " dREN_cycles"}, n_dr, v.e_dr);
      chk({tag, " dWEN_cycles"}, n_dw, v.e_dw);
      chk({tag, " irWEN_pulses"}, n_ir, 1);
      chk({tag, " regWEN_pulses"}, n_rw, int'(v.rw));
      chk({tag, " regWEN_at_WB"}, rw_at_pc, v.rw);
      chk({tag, " sc_success_at_WB"}, sc_at_pc, v.e_sc);
      chk({tag, " sc_success_pulses"}, n_sc, int'(v.e_sc));
      chk({tag, " cycle_cnt"}, cycle_cnt, exp_cycles);
      chk({tag, " instr_cnt"}, instr_cnt, exp_instr);
      chk({tag, " cycle_cnt4"}, cnt4, exp_cycles % 16);
      chk({tag, " back_in_fetch"}, iREN, 1);
   endtask

   initial begin
      int n;
      tbl.push_back(mk(K_ALU, 0, 0, 1, 32'h0,   0, 32'h0,   4, 0, 0, 0));
      tbl.push_back(mk(K_ALU, 2, 0, 0, 32'h0,   0, 32'h0,   6, 0, 0, 0));
      tbl.push_back(mk(K_LW,  0, 3, 1, 32'h40,  0, 32'h0,   8, 4, 0, 0));
      tbl.push_back(mk(K_SW,  2, 1, 0, 32'h44,  0, 32'h0,   8, 0, 2, 0));
      tbl.push_back(mk(K_LL,  0, 0, 1, 32'h100, 0, 32'h0,   5, 1, 0, 0));
      tbl.push_back(mk(K_SC,  0, 2, 1, 32'h100, 0, 32'h0,   7, 0, 3, 1));
      tbl.push_back(mk(K_SC,  0, 2, 1, 32'h100, 0, 32'h0,   5, 0, 0, 0));
      tbl.push_back(mk(K_LL,  1, 1, 1, 32'h100, 0, 32'h0,   7, 2, 0, 0));
      tbl.push_back(mk(K_SC,  0, 2, 1, 32'h100, 1, 32'h100, 5, 0, 0, 0));
      tbl.push_back(mk(K_LL,  0, 0, 1, 32'h100, 0, 32'h0,   5, 1, 0, 0));
      tbl.push_back(mk(K_SC,  0, 0, 1, 32'h104, 0, 32'h0,   5, 0, 0, 0));
      tbl.push_back(mk(K_LL,  0, 0, 1, 32'h104, 0, 32'h0,   5, 1, 0, 0));
      tbl.push_back(mk(K_SC,  0, 1, 1, 32'h104, 1, 32'h100, 6, 0, 2, 1));
      tbl.push_back(mk(K_LL,  0, 0, 1, 32'h100, 2, 32'h100, 5, 1, 0, 0));
      tbl.push_back(mk(K_SC,  0, 0, 1, 32'h100, 0, 32'h0,   5, 0, 0, 0));

      do_reset();
      chk("reset outputs", {iREN, irWEN, dREN, dWEN, regWEN, pcWEN, sc_success, halt}, 8'h80);
      chk("reset outputs4", {iREN4, irWEN4, dREN4, dWEN4, regWEN4, pcWEN4, sc4, halt4}, 8'h80);
      chk("reset cycle_cnt", cycle_cnt, 0);
      chk("reset instr_cnt", instr_cnt, 0);
      chk("reset instr_cnt4", icnt4, 0);

      foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

      // Halt in EXEC takes priority over a pending load.
      dec_halt = 1'b1; dec_dREN = 1'b1; dec_dWEN = 1'b0; dec_datomic = 1'b0; dec_regWEN = 1'b1;
      ihit = 1'b1;
      @(negedge CLK);
      ihit = 1'b0;
      @(negedge CLK);
      chk("halt in EXEC", halt, 0);
      @(negedge CLK);
      chk("halt set", halt, 1);
      chk("halt4 set", halt4, 1);
      chk("halt no iREN", iREN, 0);
      chk("halt cycle_cnt", cycle_cnt, exp_cycles + 3);
      n = 0;
      repeat (20) begin
         ihit = 1'($urandom_range(1, 0));
         dhit = 1'($urandom_range(1, 0));
         #1;
         n += int'(iREN) + int'(irWEN) + int'(dREN) + int'(dWEN) + int'(regWEN) + int'(pcWEN);
         @(negedge CLK);
      end
      ihit = 1'b0; dhit = 1'b0;
      chk("halt enables", n, 0);
      chk("halt sticky", halt, 1);
      chk("halt cycle_cnt frozen", cycle_cnt, exp_cycles + 3);
      chk("halt instr_cnt", instr_cnt, exp_instr);
      do_reset();
      dec_halt = 1'b0; dec_dREN = 1'b0; dec_regWEN = 1'b0;
      chk("post-halt reset outputs", {iREN, irWEN, dREN, dWEN, regWEN, pcWEN, sc_success, halt}, 8'h80);
      chk("post-halt cycle_cnt", cycle_cnt, 0);
      chk("post-halt instr_cnt", instr_cnt, 0);

      // Reset while a store waits in MEM.
      run_vec(mk(K_ALU, 0, 0, 1, 32'h0, 0, 32'h0, 4, 0, 0, 0), "pre-sw add");
      dec_dWEN = 1'b1; dec_regWEN = 1'b0; dec_datomic = 1'b0; daddr = 32'h80;
      ihit = 1'b1;
      @(negedge CLK);
      ihit = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      chk("sw mem dWEN", dWEN, 1);
      @(negedge CLK);
      chk("sw mem dWEN held", dWEN, 1);
      chk("sw instr_cnt unchanged", instr_cnt, 1);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      exp_cycles = 0; exp_instr = 0;
      chk("sw reset dWEN", dWEN, 0);
      chk("sw reset fetch", iREN, 1);
      chk("sw reset instr_cnt", instr_cnt, 0);
      chk("sw reset cycle_cnt", cycle_cnt, 0);
      dec_dWEN = 1'b0;

      // 4-bit counter wrap while idling in FETCH.
      repeat (15) @(negedge CLK);
      chk("cnt4 at max", cnt4, 15);
      @(negedge CLK);
      chk("cnt4 wrap", cnt4, 0);
      chk("cycle_cnt 16", cycle_cnt, 16);

      do_reset();
      for (int i = 0; i < 40; i++) begin
         vec_t v;
         v.kind  = int'($urandom_range(4, 0));
         v.fi    = int'($urandom_range(2, 0));
         v.dw    = int'($urandom_range(3, 0));
         v.rw    = 1'($urandom_range(1, 0));
         v.addr  = ($urandom_range(1, 0) != 0) ? 32'h104 : 32'h100;
         v.smode = ($urandom_range(2, 0) == 0) ? 1 : 0;
         case ($urandom_range(2, 0))
            0:       v.saddr = 32'h100;
            1:       v.saddr = 32'h104;
            default: v.saddr = 32'h200;
         endcase
         model(v);
         run_vec(v, $sformatf("rnd%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
Multicycle control sequencer for the MIPS core. It consumes the decoded control word from the control unit: aluop, regWEN, dREN/dWEN, datomic and halt. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, gating the datapath write enables and the cache requests against ihit/dhit. It also owns the LL/SC link register, counts cycles and retired instructions, and sits between the control unit, the datapath and the cache/memory interface.

Parameters:
ADDR_W, 32, width of the data address compared for the LL/SC link
CNT_W, 32, width of the cycle and instruction performance counters

Ports:
CLK  in  1  core clock
RST  in  1  synchronous, active-high reset
ihit  in  1  instruction fetch complete
dhit  in  1  data access complete
dec_halt  in  1  halt from control unit
dec_regWEN  in  1  register write request from control unit
dec_dREN  in  1  load request from control unit
dec_dWEN  in  1  store request from control unit
dec_datomic  in  1  LL (with dREN) / SC (with dWEN) qualifier
daddr  in  ADDR_W  effective data address from ALU
snoop_inv  in  1  coherence invalidation valid
snoop_addr  in  ADDR_W  invalidated address
iREN  out  1  instruction read request
irWEN  out  1  instruction register load
dREN  out  1  data read request
dWEN  out  1  data write request
regWEN  out  1  register file write enable
pcWEN  out  1  PC update enable
sc_success  out  1  SC result bit; datapath writes it to rt
halt  out  1  sticky halt
cycle_cnt  out  CNT_W  non-halted cycle count
instr_cnt  out  CNT_W  retired instruction count

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Outputs are combinational from the state register plus decoded inputs, with no extra register stage.
- Reset (synchronous, RST=1 at posedge) sets:
  - state=FETCH, link_valid=0, link_addr=0, sc_pass=0
  - cycle_cnt=0, instr_cnt=0
  - Output values in FETCH after reset: iREN=1, every other output 0.
- FETCH: iREN=1. On ihit, irWEN=1 for that cycle and next state is DECODE. Otherwise stay in FETCH.
- DECODE: one cycle, no enables asserted, next state EXEC.
- EXEC: one cycle.
  - dec_halt=1 goes to HALT; halt takes priority over everything.
  - Else dec_dREN|dec_dWEN goes to MEM.
  - Else goes to WB.
  - For an SC (dec_dWEN & dec_datomic), sc_pass is latched as link_valid & (link_addr==daddr).
- MEM:
  - Load: dREN=1.
  - Store: dWEN=1, except a failed SC (sc_pass=0), which issues no request and goes to WB after one cycle.
  - Otherwise go to WB on dhit and stay while dhit=0.
  - An issued request stays asserted and stable until dhit.
- WB: one cycle, pcWEN=1, regWEN=dec_regWEN, sc_success=sc_pass for an SC (else 0). instr_cnt increments, next state FETCH.
- HALT: halt=1, all enables 0. Sticky until RST.
- ihit outside FETCH and dhit outside MEM are ignored.
- Latency:
  - Non-memory instruction: 4 cycles when ihit arrives on the first FETCH cycle.
  - Memory instruction: 5 + dhit wait cycles.
- Link register:
  - LL completing (MEM, dREN & dec_datomic & dhit) sets link_valid=1 and link_addr=daddr.
  - Cleared by: a successful SC at WB, a snoop_inv with snoop_addr==link_addr, or RST.
  - A snoop match in the same cycle as LL completion leaves link_valid=0 (invalidate wins).
  - A snoop arriving after sc_pass is latched does not abort an issued SC write.
- Counters:
  - cycle_cnt increments every cycle state!=HALT, including cycles spent waiting.
  - Both counters wrap modulo 2^CNT_W with no saturation or flag.
- Reset mid-operation (e.g. in MEM with dREN high) returns to FETCH next cycle with dREN/dWEN dropped. The cache side must tolerate an abandoned request.

Decomposition:
- Shared package dp_types_pkg gets:
  - seq_state_t, the enum FETCH/DECODE/EXEC/MEM/WB/HALT, for bench visibility
  - a constant SEQ_STATE_W
- Sub-module llsc_link holds link_valid/link_addr, the snoop compare and the SC address compare. The sequencer instantiates it once. Everything else stays in one module.

Test Plan:
- ADD, ihit on first FETCH cycle: irWEN at cycle 0, regWEN and pcWEN at cycle 3, instr_cnt=1, cycle_cnt=4, back in FETCH at cycle 4.
- LW with dhit delayed 3 cycles: dREN held high for exactly 4 cycles in MEM, regWEN pulses once afterwards, total 8 cycles.
- LL to 0x100, then SC to 0x100 with no snoop: SC issues dWEN, sc_success=1 in WB, link_valid=0 afterwards.
- LL to 0x100, snoop_inv on 0x100, then SC to 0x100: no dWEN ever asserted, one MEM cycle, sc_success=0. A second SC to 0x104 after a fresh LL to 0x100 also fails.
- HALT in EXEC: halt=1 from the next cycle; cycle_cnt frozen over 20 further cycles; ihit/dhit pulses have no effect; RST=1 returns to FETCH with counters=0.
- RST asserted during the MEM wait of an SW: dWEN=0 and state FETCH on the following cycle, instr_cnt unchanged then cleared. Separately, preload cycle_cnt to 2^CNT_W-1 (CNT_W=4 build) and verify wrap to 0.
